// File: rtl/sram_arb_pkg.sv
// Purpose : shared encodings for the SRAM arbiter (FSM states, grant IDs, wait counter width).
// Latency : n/a (definitions only).
// Backpressure: n/a.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SETUP  = 3'b001,
    ACCESS = 3'b010,
    DONE   = 3'b011
  } state_t;

  localparam logic GNT_AVR  = 1'b0;
  localparam logic GNT_SNES = 1'b1;

  // Holds WAIT_CYCLES-1, so 1..15 strobe cycles fit in 4 bits.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Purpose : combinational 2-way winner select between AVR and SNES requests.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; caller samples o_any/o_grant only when it can start a transaction.
// Ports   : i_avr_req, i_snes_req  - request levels
//           i_last_grant            - requester served most recently
//           o_any                   - at least one request present
//           o_grant                 - winner ID (GNT_AVR / GNT_SNES)
// Build   : SRAM_ARB_FIXED_PRIO_EN selects SNES-always-wins instead of round-robin.
module rr_arb2 (
  input  logic i_avr_req,
  input  logic i_snes_req,
  input  logic i_last_grant,
  output logic o_any,
  output logic o_grant
);
  import sram_arb_pkg::*;

  assign o_any = i_avr_req | i_snes_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // History is still kept by the caller but plays no part in the decision.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign o_grant = i_snes_req ? GNT_SNES : GNT_AVR;
`else
  // On a tie, the requester that was not served last time wins.
  assign o_grant = (i_avr_req && i_snes_req) ? ~i_last_grant :
                   (i_snes_req ? GNT_SNES : GNT_AVR);
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Purpose : shares one async SRAM between the AVR and SNES requesters, driving address and
//           active-low CE/WE/OE with a 1-cycle setup, WAIT_CYCLES strobe and 1-cycle hold.
// Latency : req sampled in IDLE at edge N -> ack visible in the cycle ending at edge N+WAIT_CYCLES+2.
// Backpressure: req is level-held until ack; requests are only looked at in IDLE.
// Ports   : i_clk, i_reset (sync, active-high)
//           i_avr_*/o_avr_*, i_snes_*/o_snes_* - req/we/addr/wdata in, rdata/ack out per requester
//           o_sram_addr, io_sram_dq, o_sram_ce_n/we_n/oe_n - SRAM pins
//           o_busy (state != IDLE), o_debug (state encoding)
// Build   : SRAM_ARB_FIXED_PRIO_EN (see rr_arb2) switches ties to SNES-always-wins.
module sram_arbiter #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 19,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_avr_req,
  input  logic              i_avr_we,
  input  logic [AWIDTH-1:0] i_avr_addr,
  input  logic [DWIDTH-1:0] i_avr_wdata,
  output logic [DWIDTH-1:0] o_avr_rdata,
  output logic              o_avr_ack,
  input  logic              i_snes_req,
  input  logic              i_snes_we,
  input  logic [AWIDTH-1:0] i_snes_addr,
  input  logic [DWIDTH-1:0] i_snes_wdata,
  output logic [DWIDTH-1:0] o_snes_rdata,
  output logic              o_snes_ack,
  output logic [AWIDTH-1:0] o_sram_addr,
  inout  wire  [DWIDTH-1:0] io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_busy,
  output logic [2:0]        o_debug
);
  import sram_arb_pkg::*;

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_we;
  logic [DWIDTH-1:0]     r_wdata;
  logic [AWIDTH-1:0]     r_sram_addr;
  logic                  r_ce_n;
  logic                  r_we_n;
  logic                  r_oe_n;
  logic                  r_dq_oe;
  logic [DWIDTH-1:0]     r_avr_rdata;
  logic [DWIDTH-1:0]     r_snes_rdata;
  logic                  r_avr_ack;
  logic                  r_snes_ack;

  logic                  w_any;
  logic                  w_grant;

  rr_arb2 u_arb (
    .i_avr_req    (i_avr_req),
    .i_snes_req   (i_snes_req),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  // Strobes and acks are set on the edge that enters the state they belong to,
  // so every pin is a flop output and lines up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_grant      <= GNT_AVR;
      r_last_grant <= GNT_AVR;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_sram_addr  <= '0;
      r_ce_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_dq_oe      <= 1'b0;
      r_avr_rdata  <= '0;
      r_snes_rdata <= '0;
      r_avr_ack    <= 1'b0;
      r_snes_ack   <= 1'b0;
    end else begin
      r_avr_ack  <= 1'b0;
      r_snes_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant     <= w_grant;
            r_we        <= (w_grant == GNT_SNES) ? i_snes_we    : i_avr_we;
            r_sram_addr <= (w_grant == GNT_SNES) ? i_snes_addr  : i_avr_addr;
            r_wdata     <= (w_grant == GNT_SNES) ? i_snes_wdata : i_avr_wdata;
            r_ce_n      <= 1'b0;
            r_dq_oe     <= (w_grant == GNT_SNES) ? i_snes_we    : i_avr_we;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_cnt   <= CNT_LOAD;
          r_we_n  <= ~r_we;
          r_oe_n  <= r_we;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            // OE is still low at this edge, so the SRAM is still driving dq.
            if (!r_we) begin
              if (r_grant == GNT_SNES) r_snes_rdata <= io_sram_dq;
              else                     r_avr_rdata  <= io_sram_dq;
            end
            if (r_grant == GNT_SNES) r_snes_ack <= 1'b1;
            else                     r_avr_ack  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // CE and write data were held through DONE for write hold time.
          r_ce_n       <= 1'b1;
          r_dq_oe      <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_sram_dq   = r_dq_oe ? r_wdata : 'z;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_ce_n  = r_ce_n;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_oe_n  = r_oe_n;
  assign o_avr_rdata  = r_avr_rdata;
  assign o_snes_rdata = r_snes_rdata;
  assign o_avr_ack    = r_avr_ack;
  assign o_snes_ack   = r_snes_ack;
  assign o_busy       = (r_state != IDLE);
  assign o_debug      = r_state;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single cartridge SRAM between two requesters: the AVR (host/loader) and the SNES (console bus mirror).
- Grants one requester per transaction and drives the SRAM address and active-low CE/WE/OE strobes with fixed setup and strobe timing.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between the requester-side bus logic and the SRAM pins; all SRAM access goes through this block.

Parameters:
- DWIDTH, 8, data width of both requesters and the SRAM.
- AWIDTH, 19, SRAM address width.
- WAIT_CYCLES, 2, cycles the CE/WE or CE/OE strobe is held asserted; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- avr_req  input  1  AVR transaction request, level, held until avr_ack
- avr_we  input  1  1 = write, 0 = read; stable while avr_req is high
- avr_addr  input  AWIDTH  AVR address
- avr_wdata  input  DWIDTH  AVR write data
- avr_rdata  output  DWIDTH  AVR read data, valid when avr_ack is high
- avr_ack  output  1  one-cycle completion pulse
- snes_req, snes_we, snes_addr, snes_wdata, snes_rdata, snes_ack: same directions, widths and meanings as the AVR set, for the SNES requester
- sram_addr  output  AWIDTH  registered SRAM address
- sram_dq  inout  DWIDTH  SRAM data; driven only during write access, high-Z otherwise
- sram_ce_n, sram_we_n, sram_oe_n  output  1 each  active-low SRAM strobes
- busy  output  1  high whenever state != IDLE
- debug  output  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; sram_addr=0; strobes=1; sram_dq=Z; both acks=0; both rdata=0; busy=0; last_grant=AVR.
- Reset mid-transaction: all strobes are deasserted on the next edge and no ack is issued.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, latch grant, we, addr and wdata from the winner, then go to SETUP.
- SETUP (1 cycle):
  - sram_addr is valid and sram_ce_n=0.
  - For a write, sram_dq is driven with wdata.
  - WE and OE remain high. Go to ACCESS.
- ACCESS (WAIT_CYCLES cycles, via a 4-bit counter):
  - Write: sram_we_n=0. Read: sram_oe_n=0.
  - On the final ACCESS cycle a read captures sram_dq into the granted requester's rdata.
  - Then go to DONE.
- DONE (1 cycle):
  - WE/OE deasserted; CE and dq drive stay held for this cycle (write hold).
  - The granted ack pulses high for exactly 1 cycle.
  - last_grant is updated. Go to IDLE.
- Latency: a req first sampled in IDLE at edge N produces its ack during cycle N+WAIT_CYCLES+2. Minimum spacing between transactions is WAIT_CYCLES+3 cycles.
- Arbitration (default, round-robin):
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_grant wins.
  - After reset, the SNES wins the first tie.
- Requester side:
  - rdata of the non-granted requester is unchanged.
  - The non-granted ack stays 0.
  - A req dropped mid-transaction is ignored: the transaction completes and ack still pulses.
  - A requester must drop req in the cycle after ack, otherwise a new transaction is started.
- Write data on sram_dq is never driven in IDLE, nor in any read state.

Optional Feature:
- SRAM_ARB_FIXED_PRIO_EN defined: the SNES always wins a tie. The AVR is served only when snes_req is low in IDLE. last_grant is still tracked but not used.
- Not defined: round-robin as described above.

Decomposition:
- Package sram_arb_pkg holds:
  - state encodings (IDLE=3'b000, SETUP=3'b001, ACCESS=3'b010, DONE=3'b011);
  - grant IDs (GNT_AVR=1'b0, GNT_SNES=1'b1);
  - the width of the WAIT_CYCLES counter.
- One natural sub-module, rr_arb2: a combinational 2-way winner select from (avr_req, snes_req, last_grant). It also carries the fixed-priority variant under the macro.

Test Plan:
- Single AVR write: addr=0x00123, data=0xA5, WAIT_CYCLES=2 -> sram_ce_n low for 4 cycles, sram_we_n low for exactly 2 cycles, dq=0xA5 from SETUP through DONE, avr_ack at N+4, snes_ack stays 0.
- SNES read: SRAM model returns 0x3C at addr 0x7FFFF -> sram_oe_n low for 2 cycles, snes_rdata=0x3C with snes_ack at N+4, dq never driven by the block.
- Simultaneous requests held continuously after reset -> grant order SNES, AVR, SNES, AVR, with acks spaced 5 cycles apart. With SRAM_ARB_FIXED_PRIO_EN, the SNES is served every time while its req stays high.
- Reset asserted on the first ACCESS cycle of a write -> the next edge shows all strobes high, dq=Z, busy=0, and no ack is ever issued.
- req dropped during SETUP -> the transaction still completes and ack pulses once. Req held one cycle past ack -> a second transaction starts.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 -> strobe widths of 1 and 15 cycles, ack at N+3 and N+17 respectively.
